dmem_mmio_responder: RTL and testbench
======================================

Name: dmem_mmio_responder

Overview:
- Responder end of the CPU data-memory interface (daddr/dwdata/we in, drdata out).
- Serves a word-addressed RAM region and a small MMIO page: LED register, console TX FIFO with valid/ready drain port, status register, and an optional timer.
- Sits beside the SingleCycleCPU in top in place of plain data memory.
- Reads are combinational, so the single-cycle core gets drdata in the same cycle; writes commit on the rising clk edge.

Parameters:
- RAM_WORDS, 256, RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 4, console TX FIFO depth in bytes; power of two, at least 2.
- MMIO_BASE, 32'h8000_0000, base of the MMIO page; MMIO is selected when daddr[31:8] == MMIO_BASE[31:8].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- daddr  input  32  byte address from CPU; daddr[1:0] ignored (word access).
- dwdata  input  32  write data.
- we  input  4  byte-lane write enables; we[i] writes dwdata[8i+7:8i]; 4'b0000 means read.
- drdata  output  32  combinational read data for daddr.
- led_out  output  8  LED register contents.
- tx_data  output  8  FIFO head byte.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  consumer accepts the head byte this cycle.
- irq  output  1  timer interrupt pending; tied 0 when the timer is compiled out.

Behaviour:
- Reset (synchronous, active-high): the following clear to 0: led_out, FIFO pointers and count, overflow flag, cycle counter, compare register, irq.
  - After reset: tx_valid=0, tx_data=0.
  - RAM contents are not cleared.
- RAM region: daddr[31:8] != MMIO_BASE[31:8].
  - Index = daddr[log2(RAM_WORDS)+1:2]; higher address bits alias (wrap).
  - Write: lanes with we[i]=1 are updated at the edge; other lanes are kept.
- MMIO word offsets (daddr[7:0]):
  - 0x00 LED, RW. Only bits [7:0] exist; write uses we[0]; reads return zero-extended.
  - 0x04 CYCLE, RW (timer). Increments by 1 every cycle and wraps 0xFFFFFFFF->0. A byte-lane write loads the written lanes for that cycle (the load takes priority over the increment).
  - 0x08 TXDATA, WO.
    - A write with we[0]=1 pushes dwdata[7:0].
    - The push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
    - Otherwise the byte is dropped and the sticky overflow flag is set.
    - Reads return 0.
  - 0x0C STATUS, RO except for the clear action.
    - Fields: bit0=full, bit1=empty, bit2=overflow, bits[15:8]=count.
    - Any write with we!=0 clears overflow. If a dropped push happens in the same cycle, set wins.
  - 0x10 CMP, RW (timer): compare register, byte-lane writable.
  - 0x14 IRQACK, WO: a write with we!=0 clears irq. Reads return 0.
  - Unmapped MMIO offsets: reads return 0; writes are ignored.
- FIFO:
  - Pop when tx_valid && tx_ready; the head advances at the edge.
  - tx_data is the registered head entry; it is valid only while tx_valid=1.
  - Simultaneous push and pop when empty: the pushed byte becomes visible the next cycle; count is unchanged net of +1/-1 rules, i.e. count goes 0->1 only if the pop did not occur (a pop cannot occur when empty).
  - Simultaneous push and pop when full: both happen, count stays FIFO_DEPTH, no overflow.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Timer irq:
  - Set at the edge after CYCLE == CMP, evaluated with the pre-increment value. irq therefore rises 1 cycle after the match.
  - Sticky until an IRQACK write. Set and ack in the same cycle: set wins.
- Reset mid-operation: FIFO contents are discarded, tx_valid drops the cycle after reset is sampled, and a pending push in the reset cycle is ignored.
- No stalls: every access completes in one cycle; there is no ready/ack back to the CPU.

Optional Feature:
- Macro: MMIO_TIMER_EN.
- Defined: the CYCLE counter, CMP register, irq logic and IRQACK are implemented as above.
- Undefined: no counter or compare flops; offsets 0x04/0x10/0x14 read 0 and ignore writes; irq is constant 0.

Test Plan:
- Byte lanes: write 0xAABBCCDD to 0x0000_0010 with we=1111, then write 0x00000011 with we=0001 -> read of 0x10 returns 0xAABBCC11; read of 0x0000_0410 (alias, RAM_WORDS=256) also returns 0xAABBCC11.
- LED: write 0x1234_56A5 with we=0001 to 0x8000_0000 -> led_out=0xA5 next cycle; read returns 0x0000_00A5; after reset, led_out=0.
- FIFO fill/overflow: tx_ready=0, push 0x41..0x45 -> STATUS = 0x0000_0405 (count 4, full, overflow); then tx_ready=1 for 4 cycles -> tx_data sequence 0x41,0x42,0x43,0x44, then tx_valid=0 and STATUS bit1=1; write STATUS -> overflow clears.
- Full push+pop: FIFO full with tx_ready=1, push 0x50 in the same cycle -> count stays 4, overflow stays 0, and 0x50 appears last in the drain order.
- Timer (MMIO_TIMER_EN): write CMP=20, write CYCLE=0 -> irq rises exactly 21 cycles after the CYCLE write commits and stays high; IRQACK write -> irq=0 next cycle. Without the macro: reads of 0x04 return 0 and irq stays 0.
- Sync reset mid-drain: 3 bytes queued, assert reset for 1 cycle -> tx_valid=0, STATUS=0x0000_0002, irq=0; RAM word written before reset still reads back.

Source files
------------

// File: rtl/dmem_mmio_responder_if.sv
// CPU data-memory bus plus console TX drain port of dmem_mmio_responder.
interface dmem_mmio_responder_if;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  we;
    logic [31:0] drdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output daddr, dwdata, we, tx_ready,
        input  drdata, tx_data, tx_valid
    );

    modport slave (
        input  daddr, dwdata, we, tx_ready,
        output drdata, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus MMIO page (LED, console TX FIFO, status, timer).
// Define MMIO_TIMER_EN to build the CYCLE/CMP timer, irq and IRQACK; otherwise those read 0.
module dmem_mmio_responder #(
    parameter int          RAM_WORDS  = 256,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_mmio_responder_if.slave  bus,
    output logic [7:0]            led_out,
    output logic                  irq
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;

    logic          mmio_sel, wr_any;
    logic [5:0]    woff;
    logic [AW-1:0] ram_idx;
    logic          full, empty, pop, push_req, push_ok, drop, status_clr;
    logic          unused_addr_bits;

    assign mmio_sel   = (bus.daddr[31:8] == MMIO_BASE[31:8]);
    assign woff       = bus.daddr[7:2];
    assign ram_idx    = bus.daddr[AW+1:2];
    assign wr_any     = |bus.we;
    assign unused_addr_bits = ^bus.daddr[1:0];

    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    assign pop        = !empty && bus.tx_ready;
    assign push_req   = mmio_sel && (woff == 6'h02) && bus.we[0];
    // A pop in the same cycle frees a slot even when full.
    assign push_ok    = push_req && (!full || pop);
    assign drop       = push_req && !push_ok;
    assign status_clr = mmio_sel && (woff == 6'h03) && wr_any;

    assign bus.tx_valid = !empty;
    assign bus.tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!mmio_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.we[i]) ram[ram_idx][8*i +: 8] <= bus.dwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= bus.dwdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            led_out <= 8'h00;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)            ovf <= 1'b1;
            else if (status_clr) ovf <= 1'b0;
            if (mmio_sel && (woff == 6'h00) && bus.we[0]) led_out <= bus.dwdata[7:0];
        end
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] cycle, cmp;
    logic        irq_q, cyc_wr, cmp_wr, irq_ack;

    assign cyc_wr  = mmio_sel && (woff == 6'h01) && wr_any;
    assign cmp_wr  = mmio_sel && (woff == 6'h04) && wr_any;
    assign irq_ack = mmio_sel && (woff == 6'h05) && wr_any;
    assign irq     = irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle <= '0;
            cmp   <= '0;
            irq_q <= 1'b0;
        end else begin
            // A CPU load replaces the increment for that cycle.
            if (cyc_wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.we[i]) cycle[8*i +: 8] <= bus.dwdata[8*i +: 8];
                end
            end else begin
                cycle <= cycle + 32'd1;
            end
            for (int i = 0; i < 4; i++) begin
                if (cmp_wr && bus.we[i]) cmp[8*i +: 8] <= bus.dwdata[8*i +: 8];
            end
            if (cycle == cmp)  irq_q <= 1'b1;
            else if (irq_ack)  irq_q <= 1'b0;
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        bus.drdata = 32'h0;
        if (!mmio_sel) begin
            bus.drdata = ram[ram_idx];
        end else begin
            case (woff)
                6'h00:   bus.drdata = {24'h0, led_out};
                6'h03:   bus.drdata = {16'h0, 8'(count), 5'b0, ovf, empty, full};
`ifdef MMIO_TIMER_EN
                6'h01:   bus.drdata = cycle;
                6'h04:   bus.drdata = cmp;
`endif
                default: bus.drdata = 32'h0;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: stimulus queues expectations, a monitor compares.
module tb_dmem_mmio_responder;
    localparam logic [31:0] LED_A  = 32'h8000_0000;
    localparam logic [31:0] CYC_A  = 32'h8000_0004;
    localparam logic [31:0] TXD_A  = 32'h8000_0008;
    localparam logic [31:0] STAT_A = 32'h8000_000C;
    localparam logic [31:0] CMP_A  = 32'h8000_0010;
    localparam logic [31:0] ACK_A  = 32'h8000_0014;

    localparam int S_DRDATA = 0, S_LED = 1, S_TXV = 2, S_IRQ = 3, S_TXD = 4;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } item_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] led_out;
    logic       irq;

    item_t      sb_q[$];
    logic [7:0] tx_q[$];
    int         n_chk  = 0;
    int         n_fail = 0;

    dmem_mmio_responder_if bus();

    dmem_mmio_responder dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .led_out (led_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            S_DRDATA: return bus.drdata;
            S_LED:    return {24'h0, led_out};
            S_TXV:    return {31'h0, bus.tx_valid};
            S_IRQ:    return {31'h0, irq};
            default:  return {24'h0, bus.tx_data};
        endcase
    endfunction

    // Monitor: drains queued expectations and checks every TX handshake.
    always @(negedge clk) begin
        item_t       it;
        logic [31:0] act;
        logic [7:0]  exp_b;
        while (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            act = pick(it.sel);
            n_chk++;
            if (act !== it.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h", it.name, act, it.exp);
            end
        end
        if (bus.tx_valid && bus.tx_ready && !reset) begin
            n_chk++;
            if (tx_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_unexpected: got %h, expected no byte", bus.tx_data);
            end else begin
                exp_b = tx_q.pop_front();
                if (bus.tx_data !== exp_b) begin
                    n_fail++;
                    $display("FAIL tx_order: got %h, expected %h", bus.tx_data, exp_b);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        bus.daddr  = a;
        bus.dwdata = d;
        bus.we     = w;
        cyc();
        bus.we     = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string name);
        bus.daddr = a;
        bus.we    = 4'b0000;
        sb_q.push_back('{S_DRDATA, e, name});
        cyc();
    endtask

    task automatic chk(input int sel, input logic [31:0] e, input string name);
        sb_q.push_back('{sel, e, name});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        bus.daddr    = 32'h0;
        bus.dwdata   = 32'h0;
        bus.we       = 4'b0000;
        bus.tx_ready = 1'b0;
        repeat (2) cyc();
        reset = 1'b0;
        chk(S_LED, 32'h0, "reset_led");
        chk(S_TXV, 32'h0, "reset_txvalid");
        chk(S_TXD, 32'h0, "reset_txdata");
        chk(S_IRQ, 32'h0, "reset_irq");
        rd(STAT_A, 32'h0000_0002, "reset_status");

        // RAM byte lanes and aliasing
        wr(32'h0000_0010, 32'hAABB_CCDD, 4'b1111);
        wr(32'h0000_0010, 32'h0000_0011, 4'b0001);
        rd(32'h0000_0010, 32'hAABB_CC11, "ram_lanes");
        rd(32'h0000_0410, 32'hAABB_CC11, "ram_alias");

        // LED and unmapped/write-only reads
        wr(LED_A, 32'h1234_56A5, 4'b0001);
        chk(S_LED, 32'h0000_00A5, "led_out");
        rd(LED_A, 32'h0000_00A5, "led_read");
        rd(32'h8000_0020, 32'h0, "unmapped_read");
        rd(TXD_A, 32'h0, "txdata_read");

        // FIFO fill with overflow, then drain
        for (int k = 0; k < 5; k++) wr(TXD_A, 32'h41 + k, 4'b0001);
        rd(STAT_A, 32'h0000_0405, "status_full_ovf");
        for (int k = 0; k < 4; k++) tx_q.push_back(8'(8'h41 + k));
        bus.tx_ready = 1'b1;
        repeat (4) cyc();
        chk(S_TXV, 32'h0, "drained_txvalid");
        rd(STAT_A, 32'h0000_0006, "status_empty_ovf");
        bus.tx_ready = 1'b0;
        wr(STAT_A, 32'h0, 4'b0001);
        rd(STAT_A, 32'h0000_0002, "status_ovf_clear");

        // Push and pop together while full
        for (int k = 0; k < 4; k++) wr(TXD_A, 32'h51 + k, 4'b0001);
        rd(STAT_A, 32'h0000_0401, "status_full");
        tx_q.push_back(8'h51);
        tx_q.push_back(8'h52);
        tx_q.push_back(8'h53);
        tx_q.push_back(8'h54);
        tx_q.push_back(8'h50);
        bus.tx_ready = 1'b1;
        wr(TXD_A, 32'h50, 4'b0001);
        bus.tx_ready = 1'b0;
        rd(STAT_A, 32'h0000_0401, "full_pushpop_status");
        bus.tx_ready = 1'b1;
        repeat (4) cyc();
        chk(S_TXV, 32'h0, "full_pushpop_drained");

        // Push into an empty FIFO while the consumer is ready
        tx_q.push_back(8'h60);
        wr(TXD_A, 32'h60, 4'b0001);
        chk(S_TXV, 32'h1, "empty_push_visible");
        cyc();
        bus.tx_ready = 1'b0;
        chk(S_TXV, 32'h0, "empty_push_drained");

`ifdef MMIO_TIMER_EN
        wr(CMP_A, 32'd20, 4'b1111);
        rd(CMP_A, 32'd20, "cmp_read");
        wr(ACK_A, 32'h1, 4'b1111);
        chk(S_IRQ, 32'h0, "irq_pre_ack");
        wr(CYC_A, 32'h0, 4'b1111);
        rd(CYC_A, 32'h0, "cycle_load");
        repeat (19) cyc();
        chk(S_IRQ, 32'h0, "irq_before_match");
        cyc();
        chk(S_IRQ, 32'h1, "irq_rise");
        cyc();
        chk(S_IRQ, 32'h1, "irq_sticky");
        wr(ACK_A, 32'h1, 4'b0001);
        chk(S_IRQ, 32'h0, "irq_ack");
`else
        wr(CYC_A, 32'hFFFF_FFFF, 4'b1111);
        rd(CYC_A, 32'h0, "cycle_absent");
        wr(CMP_A, 32'h0000_0005, 4'b1111);
        rd(CMP_A, 32'h0, "cmp_absent");
        chk(S_IRQ, 32'h0, "irq_absent");
`endif

        // Synchronous reset mid-drain
        wr(32'h0000_0020, 32'hCAFE_F00D, 4'b1111);
        for (int k = 0; k < 3; k++) wr(TXD_A, 32'h70 + k, 4'b0001);
        chk(S_TXV, 32'h1, "queued_txvalid");
        reset      = 1'b1;
        bus.daddr  = TXD_A;
        bus.dwdata = 32'h77;
        bus.we     = 4'b0001;
        cyc();
        reset  = 1'b0;
        bus.we = 4'b0000;
        chk(S_TXV, 32'h0, "midreset_txvalid");
        chk(S_IRQ, 32'h0, "midreset_irq");
        chk(S_LED, 32'h0, "midreset_led");
        rd(STAT_A, 32'h0000_0002, "midreset_status");
        rd(32'h0000_0020, 32'hCAFE_F00D, "midreset_ram");
        bus.tx_ready = 1'b1;
        repeat (2) cyc();
        bus.tx_ready = 1'b0;
        cyc();

        n_chk++;
        if (tx_q.size() != 0) begin
            n_fail++;
            $display("FAIL tx_leftover: got %0d bytes undelivered, expected 0", tx_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
